// File: rtl/iir_stereo_sched.sv
// iir_stereo_sched: round-robin scheduler that time-shares one IIR engine between
// the left and right channels of a stereo stream.
//
// Each sample moves through IDLE -> READ -> START -> WAIT -> WRITE. It is popped
// from the selected channel's first-word-fall-through input FIFO, handed to the
// engine, and the engine's result is pushed unmodified into that channel's
// output FIFO.
//
// Ports
//   clock, reset                  clock; synchronous active-low reset
//   l_in_dout/l_in_rd_en/l_in_empty   left input FIFO read side (FWFT)
//   r_in_dout/r_in_rd_en/r_in_empty   right input FIFO read side (FWFT)
//   eng_x, eng_ch, eng_start      engine request (eng_ch: 0=L, 1=R)
//   eng_y, eng_done               engine result, valid in the eng_done cycle
//   l_out_din/l_out_wr_en/l_out_full  left output FIFO write side
//   r_out_din/r_out_wr_en/r_out_full  right output FIFO write side
//   busy                          high whenever the FSM is not in IDLE
//   stall_cnt                     (IIR_SCHED_STALL_CNT_EN only) count of WRITE
//                                 cycles spent blocked by a full output FIFO
//
// Build option: define IIR_SCHED_STALL_CNT_EN to add the stall_cnt port and counter.
module iir_stereo_sched #(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] l_in_dout,
    output logic                  l_in_rd_en,
    input  logic                  l_in_empty,
    input  logic [DATA_WIDTH-1:0] r_in_dout,
    output logic                  r_in_rd_en,
    input  logic                  r_in_empty,
    output logic [DATA_WIDTH-1:0] eng_x,
    output logic                  eng_ch,
    output logic                  eng_start,
    input  logic [DATA_WIDTH-1:0] eng_y,
    input  logic                  eng_done,
    output logic [DATA_WIDTH-1:0] l_out_din,
    output logic                  l_out_wr_en,
    input  logic                  l_out_full,
    output logic [DATA_WIDTH-1:0] r_out_din,
    output logic                  r_out_wr_en,
    input  logic                  r_out_full,
    output logic                  busy
`ifdef IIR_SCHED_STALL_CNT_EN
    ,
    output logic [15:0]           stall_cnt
`endif
);

    localparam int unsigned STALL_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_START = 3'd2,
        ST_WAIT  = 3'd3,
        ST_WRITE = 3'd4
    } state_t;

    state_t                state;
    logic                  cur_ch;
    logic                  last_ch;
    logic [DATA_WIDTH-1:0] x_reg;
    logic [DATA_WIDTH-1:0] y_reg;

    logic                  sel_ch;
    logic                  dst_full;
    logic                  in_read;
    logic                  in_start;
    logic                  in_write;

    // Round-robin pick. On a tie, the channel not served last wins. Otherwise
    // the single eligible channel wins: an empty L FIFO means R is selected.
    assign sel_ch   = (!l_in_empty && !r_in_empty) ? ~last_ch : l_in_empty;
    assign dst_full = cur_ch ? r_out_full : l_out_full;

    // Strobes decode the state register. Qualifying them with reset keeps every
    // output low in the cycle that reset is sampled, including an aborted
    // transaction.
    assign in_read  = reset && (state == ST_READ);
    assign in_start = reset && (state == ST_START);
    assign in_write = reset && (state == ST_WRITE);

    assign l_in_rd_en  = in_read && !cur_ch;
    assign r_in_rd_en  = in_read &&  cur_ch;

    assign eng_start   = in_start;
    assign eng_x       = in_start ? x_reg : '0;
    assign eng_ch      = in_start && cur_ch;

    assign l_out_wr_en = in_write && !cur_ch && !l_out_full;
    assign r_out_wr_en = in_write &&  cur_ch && !r_out_full;
    assign l_out_din   = (in_write && !cur_ch) ? y_reg : '0;
    assign r_out_din   = (in_write &&  cur_ch) ? y_reg : '0;

    assign busy        = reset && (state != ST_IDLE);

    // Transaction sequencer. Because eng_done is only examined in ST_WAIT,
    // done pulses that arrive in any other state have no effect.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= ST_IDLE;
            cur_ch  <= 1'b0;
            last_ch <= 1'b1;
            x_reg   <= '0;
            y_reg   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!l_in_empty || !r_in_empty) begin
                        cur_ch <= sel_ch;
                        state  <= ST_READ;
                    end
                end
                ST_READ: begin
                    x_reg <= cur_ch ? r_in_dout : l_in_dout;
                    state <= ST_START;
                end
                ST_START: begin
                    state <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (eng_done) begin
                        y_reg <= eng_y;
                        state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!dst_full) begin
                        last_ch <= cur_ch;
                        state   <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef IIR_SCHED_STALL_CNT_EN
    logic [STALL_W-1:0] stall_q;

    // Saturating count of cycles spent in ST_WRITE with the destination FIFO full.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_q <= '0;
        end else if ((state == ST_WRITE) && dst_full && (stall_q != {STALL_W{1'b1}})) begin
            stall_q <= stall_q + STALL_W'(1);
        end
    end

    assign stall_cnt = reset ? stall_q : '0;
`endif

endmodule

// File: tb/tb_iir_stereo_sched.sv
// tb_iir_stereo_sched: randomized, self-checking bench for iir_stereo_sched.
// The bench models the input and output FIFOs and an engine that returns x+1
// after a programmable latency. A transaction-level model predicts the strobes,
// busy, the engine request and the written data on every cycle, and literal
// expectations pin the directed scenarios.
module tb_iir_stereo_sched;

    localparam int unsigned DW = 32;

    logic          clock = 1'b0;
    logic          reset;
    logic [DW-1:0] l_in_dout, r_in_dout, eng_x, eng_y, l_out_din, r_out_din;
    logic          l_in_rd_en, l_in_empty, r_in_rd_en, r_in_empty;
    logic          eng_ch, eng_start, eng_done;
    logic          l_out_wr_en, l_out_full, r_out_wr_en, r_out_full, busy;
`ifdef IIR_SCHED_STALL_CNT_EN
    logic [15:0]   stall_cnt;
    logic [15:0]   stall_exp;
`endif

    always #5 clock = ~clock;

    iir_stereo_sched #(.DATA_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .l_in_dout(l_in_dout), .l_in_rd_en(l_in_rd_en), .l_in_empty(l_in_empty),
        .r_in_dout(r_in_dout), .r_in_rd_en(r_in_rd_en), .r_in_empty(r_in_empty),
        .eng_x(eng_x), .eng_ch(eng_ch), .eng_start(eng_start),
        .eng_y(eng_y), .eng_done(eng_done),
        .l_out_din(l_out_din), .l_out_wr_en(l_out_wr_en), .l_out_full(l_out_full),
        .r_out_din(r_out_din), .r_out_wr_en(r_out_wr_en), .r_out_full(r_out_full),
        .busy(busy)
`ifdef IIR_SCHED_STALL_CNT_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    // Environment: FIFO contents, stimulus knobs and engine state
    logic [DW-1:0] lq[$], rq[$];
    bit  rst_knob, full_force_l, full_force_r, rand_full, rand_lat, rand_spur, spur;
    int  lat_fix = 3;
    int  eng_rem = 0;
    logic [DW-1:0] eng_val;

    // Transaction-level model of the scheduler
    bit  m_pend_read, m_pend_ch, m_active, m_ch, m_start_due, m_waiting, m_have_y, m_last;
    logic [DW-1:0] m_x, m_y;

    // Log of the writes the DUT actually performed
    int  wr_ch_q[$], wr_c_q[$];
    logic [DW-1:0] wr_d_q[$];
    int  rd_l_cnt = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, got, exp);
        end
    endtask

    task automatic model_reset();
        m_pend_read = 0; m_active = 0; m_start_due = 0; m_waiting = 0; m_have_y = 0;
        m_last = 1;
`ifdef IIR_SCHED_STALL_CNT_EN
        stall_exp = '0;
`endif
    endtask

    task automatic clear_log();
        wr_ch_q.delete(); wr_c_q.delete(); wr_d_q.delete();
    endtask

    task automatic drive_inputs();
        reset      = rst_knob;
        l_in_empty = (lq.size() == 0);
        r_in_empty = (rq.size() == 0);
        l_in_dout  = (lq.size() > 0) ? lq[0] : '0;
        r_in_dout  = (rq.size() > 0) ? rq[0] : '0;
        l_out_full = full_force_l | (rand_full & ($urandom_range(0, 1) == 1));
        r_out_full = full_force_r | (rand_full & ($urandom_range(0, 1) == 1));
        if (spur || (rand_spur && eng_rem == 0 && !eng_done && $urandom_range(0, 3) == 0)) begin
            eng_done = 1'b1;
            eng_y    = $urandom;
        end
        spur = 0;
    endtask

    task automatic engine_advance();
        eng_done = 1'b0;
        if (eng_rem > 0) begin
            eng_rem--;
            if (eng_rem == 0) begin
                eng_done = 1'b1;
                eng_y    = eng_val;
            end
        end
    endtask

    // Per-cycle compare against the model, then advance the model by one cycle
    task automatic check_cycle();
        bit avl_l, avl_r, idle_now, exp_wr_l, exp_wr_r;
        if (!reset) begin
            check("rst_strobes", {l_in_rd_en, r_in_rd_en, eng_start, eng_ch, l_out_wr_en, r_out_wr_en, busy}, 0);
            check("rst_eng_x", eng_x, 0);
            check("rst_dins", {l_out_din, r_out_din}, 0);
`ifdef IIR_SCHED_STALL_CNT_EN
            check("rst_stall_cnt", stall_cnt, 0);
`endif
            model_reset();
            return;
        end
        if (l_in_rd_en) rd_l_cnt++;
        if (l_out_wr_en) begin wr_ch_q.push_back(0); wr_d_q.push_back(l_out_din); wr_c_q.push_back(cyc); end
        if (r_out_wr_en) begin wr_ch_q.push_back(1); wr_d_q.push_back(r_out_din); wr_c_q.push_back(cyc); end

        avl_l    = !l_in_empty;
        avl_r    = !r_in_empty;
        idle_now = !m_active && !m_pend_read;
        exp_wr_l = m_have_y && !m_ch && !l_out_full;
        exp_wr_r = m_have_y &&  m_ch && !r_out_full;

        check("rd_mutex", l_in_rd_en & r_in_rd_en, 0);
        check("wr_mutex", l_out_wr_en & r_out_wr_en, 0);
        check("l_in_rd_en", l_in_rd_en, m_pend_read && !m_pend_ch);
        check("r_in_rd_en", r_in_rd_en, m_pend_read && m_pend_ch);
        check("eng_start", eng_start, m_start_due);
        if (m_start_due) begin
            check("eng_x", eng_x, m_x);
            check("eng_ch", eng_ch, m_ch);
        end
        check("busy", busy, m_pend_read || m_active);
        check("l_out_wr_en", l_out_wr_en, exp_wr_l);
        check("r_out_wr_en", r_out_wr_en, exp_wr_r);
        if (exp_wr_l) begin check("l_out_din", l_out_din, m_y); check("r_out_din_idle", r_out_din, 0); end
        if (exp_wr_r) begin check("r_out_din", r_out_din, m_y); check("l_out_din_idle", l_out_din, 0); end
`ifdef IIR_SCHED_STALL_CNT_EN
        check("stall_cnt", stall_cnt, stall_exp);
`endif

        // Engine: answer x+1 after the chosen latency
        if (eng_start) begin
            eng_rem = rand_lat ? $urandom_range(1, 4) : lat_fix;
            eng_val = eng_x + 1;
        end

        if (m_pend_read) begin
            m_pend_read = 0;
            if ((m_pend_ch ? rq.size() : lq.size()) == 0) begin
                check("read_from_empty", 1, 0);
            end else begin
                m_x = m_pend_ch ? rq.pop_front() : lq.pop_front();
                m_active = 1; m_ch = m_pend_ch; m_start_due = 1;
            end
        end else if (m_start_due) begin
            m_start_due = 0; m_waiting = 1;
        end else if (m_waiting) begin
            if (eng_done) begin m_waiting = 0; m_have_y = 1; m_y = eng_y; end
        end else if (m_have_y) begin
            if (m_ch ? r_out_full : l_out_full) begin
`ifdef IIR_SCHED_STALL_CNT_EN
                if (stall_exp != 16'hFFFF) stall_exp = stall_exp + 16'd1;
`endif
            end else begin
                m_have_y = 0; m_active = 0; m_last = m_ch;
            end
        end
        if (idle_now && (avl_l || avl_r)) begin
            m_pend_read = 1;
            m_pend_ch   = (avl_l && avl_r) ? !m_last : !avl_l;
        end
    endtask

    task automatic step();
        drive_inputs();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        #1;
        cyc++;
        engine_advance();
    endtask

    task automatic wait_idle(input int bound);
        int k = 0;
        while (k < bound && !(lq.size() == 0 && rq.size() == 0 && !m_active && !m_pend_read)) begin
            step();
            k++;
        end
        check("idle_reached", k < bound, 1);
    endtask

    initial begin
        int rel, rd0, viol, n_l, k;
        rst_knob = 0; full_force_l = 0; full_force_r = 0;
        rand_full = 0; rand_lat = 0; rand_spur = 0; spur = 0;
        eng_done = 0; eng_y = '0;
        model_reset();
        drive_inputs();
        @(posedge clock);
        #1;

        // Reset, then L=0x10 / R=0x20 present at release, engine latency 3
        repeat (3) step();
        lq.push_back(32'h10); rq.push_back(32'h20);
        rst_knob = 1; rel = cyc;
        wait_idle(100);
        check("t028_nwr", wr_ch_q.size(), 2);
        if (wr_ch_q.size() >= 2) begin
            check("t028_ch0", wr_ch_q[0], 0);
            check("t028_d0", wr_d_q[0], 32'h11);
            check("t028_cyc0", wr_c_q[0] - rel, 6);
            check("t028_ch1", wr_ch_q[1], 1);
            check("t028_d1", wr_d_q[1], 32'h21);
            check("t028_cyc1", wr_c_q[1] - rel, 13);
        end

        // Only R has data: three back-to-back R transactions
        clear_log(); rd0 = rd_l_cnt;
        rq.push_back(32'hA0); rq.push_back(32'hA1); rq.push_back(32'hA2);
        wait_idle(100);
        check("t029_nwr", wr_ch_q.size(), 3);
        check("t029_no_l_rd", rd_l_cnt - rd0, 0);
        if (wr_ch_q.size() == 3) begin
            check("t029_all_r", wr_ch_q[0] + wr_ch_q[1] + wr_ch_q[2], 3);
            check("t029_d2", wr_d_q[2], 32'hA3);
            check("t029_span", wr_c_q[2] - wr_c_q[0], 14);
        end

        // Spurious eng_done in IDLE and in START
        clear_log();
        spur = 1; step(); step(); spur = 1; step(); step();
        check("t031_idle_nwr", wr_ch_q.size(), 0);
        lat_fix = 2;
        lq.push_back(32'h50);
        step(); step(); spur = 1; step();
        wait_idle(50);
        check("t031_nwr", wr_ch_q.size(), 1);
        if (wr_ch_q.size() == 1) check("t031_d", wr_d_q[0], 32'h51);

        // Left output full for 10 WRITE cycles
        clear_log(); lat_fix = 3; full_force_l = 1;
        lq.push_back(32'h55);
        k = 0;
        while (!m_have_y && k < 50) begin step(); k++; end
        check("t030_reached_write", k < 50, 1);
        repeat (10) step();
        check("t030_no_wr_while_full", wr_ch_q.size(), 0);
        full_force_l = 0;
        wait_idle(50);
        check("t030_nwr", wr_ch_q.size(), 1);
        if (wr_ch_q.size() == 1) check("t030_d", wr_d_q[0], 32'h56);
`ifdef IIR_SCHED_STALL_CNT_EN
        check("t030_stall_cnt", stall_cnt, 16'd10);
`endif

        // Reset in WAIT: aborted R result never written, next tie goes to L
        lat_fix = 4;
        lq.push_back(32'h70);
        wait_idle(50);
        clear_log();
        rq.push_back(32'h41);
        k = 0;
        while (!m_waiting && k < 50) begin step(); k++; end
        check("t032_reached_wait", k < 50, 1);
        rst_knob = 0;
        lq.push_back(32'h31); rq.push_back(32'h60);
        step();
        rst_knob = 1;
        wait_idle(100);
        check("t032_nwr", wr_ch_q.size(), 2);
        if (wr_ch_q.size() == 2) begin
            check("t032_ch0", wr_ch_q[0], 0);
            check("t032_d0", wr_d_q[0], 32'h32);
            check("t032_d1", wr_d_q[1], 32'h61);
        end

        // 100 samples on each channel: strict alternation
        clear_log(); rand_lat = 1;
        for (int i = 0; i < 100; i++) begin
            lq.push_back($urandom); rq.push_back($urandom);
        end
        wait_idle(5000);
        viol = 0; n_l = 0;
        for (int i = 0; i < wr_ch_q.size(); i++) begin
            if (wr_ch_q[i] == 0) n_l++;
            if (i > 0 && wr_ch_q[i] == wr_ch_q[i-1]) viol++;
        end
        check("t033_nwr", wr_ch_q.size(), 200);
        check("t033_alternation", viol, 0);
        check("t033_n_l", n_l, 100);

        // Random traffic, backpressure, spurious done and occasional resets
        rand_full = 1; rand_spur = 1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 3) == 0) lq.push_back($urandom);
            if ($urandom_range(0, 3) == 0) rq.push_back($urandom);
            rst_knob = ($urandom_range(0, 199) != 0);
            step();
        end
        rst_knob = 1; rand_full = 0; rand_spur = 0;
        wait_idle(5000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
